// File: rtl/audio_sample_injector.sv
// -----------------------------------------------------------------------------
// audio_sample_injector
//
// Feeds audio samples into the effect engine's shared local RAM mailbox.
// Each accepted sample is written to the INPUT word, READY_TO_GET is set to 1,
// and READ_FINISH is polled until the consumer marks it non-zero.
//
// On success, READ_FINISH and READY_TO_GET are cleared and sample_count is
// incremented. If the poll budget runs out, timeout_flag is set and only
// READY_TO_GET is cleared.
//
// Every RAM access is a three-cycle SETUP / EDGE / HOLD sequence. There is
// exactly one loc_ramclk high cycle per access, and the address and write
// data stay stable for all three cycles.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-low reset
//   sample_in      in   32-bit audio sample
//   sample_valid   in   sample_in valid
//   sample_ready   out  ready for a sample (IDLE and out of reset)
//   loc_readdata   in   RAM read data
//   loc_writedata  out  RAM write data
//   loc_ramaddress out  RAM word address
//   loc_ramclk     out  RAM clock strobe (RAM samples on its rising edge)
//   loc_ramread    out  RAM read enable
//   loc_ramwrite   out  RAM write enable
//   busy           out  high whenever not IDLE
//   timeout_flag   out  sticky poll-timeout indicator
//   sample_count   out  samples acknowledged by the consumer (wraps)
// -----------------------------------------------------------------------------
module audio_sample_injector #(
  parameter logic [4:0]  ADDR_INPUT        = 5'd3,
  parameter logic [4:0]  ADDR_READ_FINISH  = 5'd4,
  parameter logic [4:0]  ADDR_READY_TO_GET = 5'd6,
  parameter int unsigned POLL_GAP          = 8,
  parameter int unsigned TIMEOUT_POLLS     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [31:0] loc_readdata,
  output logic [31:0] loc_writedata,
  output logic [4:0]  loc_ramaddress,
  output logic        loc_ramclk,
  output logic        loc_ramread,
  output logic        loc_ramwrite,
  output logic        busy,
  output logic        timeout_flag,
  output logic [15:0] sample_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_INPUT = 3'd1,
    S_WR_RDY   = 3'd2,
    S_POLL     = 3'd3,
    S_CHECK    = 3'd4,
    S_WAIT     = 3'd5,
    S_CLR_FIN  = 3'd6,
    S_CLR_RDY  = 3'd7
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_POLLS);

  state_t      r_state;
  logic [1:0]  r_phase;     // 0 = SETUP, 1 = EDGE, 2 = HOLD
  logic [31:0] r_rdata;
  logic [7:0]  r_poll_cnt;
  logic [7:0]  r_gap_cnt;
  logic [4:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_ramclk;
  logic        r_ramread;
  logic        r_ramwrite;
  logic        r_busy;
  logic        r_timeout;
  logic [15:0] r_count;

  logic        w_accept;
  logic [8:0]  w_poll_next;
  logic        w_finished;

  // Ready is the only combinational output, so it drops in the same cycle
  // that reset is asserted.
  assign sample_ready = (r_state == S_IDLE) & reset;
  assign w_accept     = sample_valid & sample_ready;
  assign w_poll_next  = {1'b0, r_poll_cnt} + 9'd1;
  assign w_finished   = (r_rdata != 32'd0);

  // Sequencer: each transition into an access state also loads that access's
  // SETUP outputs, so the strobe lands in the second cycle of every access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_phase    <= 2'd0;
      r_rdata    <= 32'd0;
      r_poll_cnt <= 8'd0;
      r_gap_cnt  <= 8'd0;
      r_addr     <= 5'd0;
      r_wdata    <= 32'd0;
      r_ramclk   <= 1'b0;
      r_ramread  <= 1'b0;
      r_ramwrite <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_count    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_WR_INPUT;
            r_phase    <= 2'd0;
            r_busy     <= 1'b1;
            r_addr     <= ADDR_INPUT;
            r_wdata    <= sample_in;
            r_ramwrite <= 1'b1;
          end
        end

        S_WR_INPUT, S_WR_RDY, S_POLL, S_CLR_FIN, S_CLR_RDY: begin
          case (r_phase)
            2'd0: begin
              r_ramclk <= 1'b1;
              r_phase  <= 2'd1;
            end
            2'd1: begin
              r_ramclk   <= 1'b0;
              r_ramwrite <= 1'b0;
              r_ramread  <= 1'b0;
              r_phase    <= 2'd2;
            end
            default: begin
              // End of HOLD: finish this access and set up the next one.
              r_phase <= 2'd0;
              case (r_state)
                S_WR_INPUT: begin
                  r_state    <= S_WR_RDY;
                  r_addr     <= ADDR_READY_TO_GET;
                  r_wdata    <= 32'd1;
                  r_ramwrite <= 1'b1;
                end
                S_WR_RDY: begin
                  r_state   <= S_POLL;
                  r_addr    <= ADDR_READ_FINISH;
                  r_wdata   <= 32'd0;
                  r_ramread <= 1'b1;
                end
                S_POLL: begin
                  r_rdata <= loc_readdata;
                  r_state <= S_CHECK;
                end
                S_CLR_FIN: begin
                  r_count    <= r_count + 16'd1;
                  r_state    <= S_CLR_RDY;
                  r_addr     <= ADDR_READY_TO_GET;
                  r_wdata    <= 32'd0;
                  r_ramwrite <= 1'b1;
                end
                default: begin
                  r_poll_cnt <= 8'd0;
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                end
              endcase
            end
          endcase
        end

        S_CHECK: begin
          if (w_finished) begin
            r_state    <= S_CLR_FIN;
            r_addr     <= ADDR_READ_FINISH;
            r_wdata    <= 32'd0;
            r_ramwrite <= 1'b1;
          end else if (w_poll_next < TO_LIMIT) begin
            r_poll_cnt <= w_poll_next[7:0];
            r_gap_cnt  <= 8'd0;
            r_state    <= S_WAIT;
          end else begin
            // Give up on this sample; READ_FINISH is left untouched.
            r_timeout  <= 1'b1;
            r_state    <= S_CLR_RDY;
            r_addr     <= ADDR_READY_TO_GET;
            r_wdata    <= 32'd0;
            r_ramwrite <= 1'b1;
          end
        end

        S_WAIT: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= 8'd0;
            r_state   <= S_POLL;
            r_addr    <= ADDR_READ_FINISH;
            r_wdata   <= 32'd0;
            r_ramread <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign loc_writedata  = r_wdata;
  assign loc_ramaddress = r_addr;
  assign loc_ramclk     = r_ramclk;
  assign loc_ramread    = r_ramread;
  assign loc_ramwrite   = r_ramwrite;
  assign busy           = r_busy;
  assign timeout_flag   = r_timeout;
  assign sample_count   = r_count;

endmodule

// File: tb/tb_audio_sample_injector.sv
// Bench for audio_sample_injector: a RAM model answers the strobed loc_* port,
// READ_FINISH replies come from a script queue, and every expected RAM access
// (kind, address, data, strobe cycle) is queued when a sample is offered and
// compared as each strobe is observed.
module tb_audio_sample_injector;

  localparam int GAP = 8;
  localparam int TOP = 4;
  localparam int PER = GAP + 4;   // strobe spacing between successive polls

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sample_in = 32'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [31:0] loc_readdata = 32'd0;
  logic [31:0] loc_writedata;
  logic [4:0]  loc_ramaddress;
  logic        loc_ramclk;
  logic        loc_ramread;
  logic        loc_ramwrite;
  logic        busy;
  logic        timeout_flag;
  logic [15:0] sample_count;

  audio_sample_injector #(
    .ADDR_INPUT(5'd3), .ADDR_READ_FINISH(5'd4), .ADDR_READY_TO_GET(5'd6),
    .POLL_GAP(GAP), .TIMEOUT_POLLS(TOP)
  ) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .loc_readdata(loc_readdata),
    .loc_writedata(loc_writedata), .loc_ramaddress(loc_ramaddress),
    .loc_ramclk(loc_ramclk), .loc_ramread(loc_ramread), .loc_ramwrite(loc_ramwrite),
    .busy(busy), .timeout_flag(timeout_flag), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  kind;   // {write, read}
    logic [4:0]  addr;
    logic [31:0] data;
    int          t;      // posedge number that raised loc_ramclk
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] fin_q[$];
  logic [31:0] mem[0:31];
  acc_t        mon_o, mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_count = 16'd0;

  // RAM model and access scoreboard, sampled mid-cycle while the strobe is high.
  always @(negedge clk) begin
    if (loc_ramclk === 1'b1) begin
      mon_o.kind = {loc_ramwrite, loc_ramread};
      mon_o.addr = loc_ramaddress;
      mon_o.data = (loc_ramwrite === 1'b1) ? loc_writedata : 32'd0;
      mon_o.t    = cyc;
      if (loc_ramwrite === 1'b1) mem[loc_ramaddress] = loc_writedata;
      if (loc_ramread === 1'b1) begin
        if (loc_ramaddress == 5'd4)
          loc_readdata = (fin_q.size() > 0) ? fin_q.pop_front() : 32'd0;
        else
          loc_readdata = mem[loc_ramaddress];
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL access_unexpected got kind=%b addr=%0d data=%h t=%0d, required no access",
                 mon_o.kind, mon_o.addr, mon_o.data, mon_o.t);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          n_bad++;
          $display("FAIL access got kind=%b addr=%0d data=%h t=%0d, required kind=%b addr=%0d data=%h t=%0d",
                   mon_o.kind, mon_o.addr, mon_o.data, mon_o.t,
                   mon_e.kind, mon_e.addr, mon_e.data, mon_e.t);
        end
      end
    end
  end

  // Queue the access sequence for a sample accepted at posedge a.
  task automatic push_expected(input logic [31:0] d, input int polls, input bit done,
                               input int a, output int idle_at);
    int last;
    exp_q.push_back('{2'b10, 5'd3, d, a + 1});
    exp_q.push_back('{2'b10, 5'd6, 32'd1, a + 4});
    for (int k = 0; k < polls; k++) exp_q.push_back('{2'b01, 5'd4, 32'd0, a + 7 + PER * k});
    last = a + 7 + PER * (polls - 1);
    if (done) begin
      exp_q.push_back('{2'b10, 5'd4, 32'd0, last + 4});
      exp_q.push_back('{2'b10, 5'd6, 32'd0, last + 7});
      idle_at = last + 9;
    end else begin
      exp_q.push_back('{2'b10, 5'd6, 32'd0, last + 4});
      idle_at = last + 6;
    end
  endtask

  // Offer one sample (called at a negedge); returns the accept posedge.
  task automatic post_sample(input logic [31:0] d, input int polls, input bit done,
                             output int a, output int idle_at, output bit ok);
    ok = 1'b0; a = 0; idle_at = 0;
    sample_in = d; sample_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sample_ready === 1'b1) begin
        a = cyc + 1; ok = 1'b1;
        push_expected(d, polls, done, a, idle_at);
      end else @(negedge clk);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin t = cyc; ok = 1'b1; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; sample_valid = 1'b1; sample_in = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    n_cmp++; if ({loc_ramclk, loc_ramread, loc_ramwrite} !== 3'b000) begin n_bad++;
      $display("FAIL reset_strobes got %b required 000", {loc_ramclk, loc_ramread, loc_ramwrite}); end
    n_cmp++; if ({loc_ramaddress, loc_writedata} !== 37'd0) begin n_bad++;
      $display("FAIL reset_addr_data got %h/%h required 0/0", loc_ramaddress, loc_writedata); end
    n_cmp++; if (sample_ready !== 1'b0) begin n_bad++;
      $display("FAIL reset_ready got %b required 0", sample_ready); end
    n_cmp++; if ({busy, timeout_flag, sample_count} !== 18'd0) begin n_bad++;
      $display("FAIL reset_status got %b %b %h required 0 0 0000", busy, timeout_flag, sample_count); end
    sample_valid = 1'b0; reset = 1'b1;
    #1;
    n_cmp++; if (sample_ready !== 1'b1) begin n_bad++;
      $display("FAIL release_ready got %b required 1", sample_ready); end
    @(negedge clk);
  endtask

  task automatic test_single;
    int a, idle, t; bit ok, ok2;
    fin_q.delete(); fin_q.push_back(32'd1);
    post_sample(32'h0000_ABCD, 1, 1'b1, a, idle, ok);
    wait_idle(t, ok2);
    n_cmp++; if (!(ok && ok2)) begin n_bad++;
      $display("FAIL single_handshake got accept=%0d idle=%0d required 1 1", ok, ok2); end
    n_cmp++; if (t !== idle) begin n_bad++;
      $display("FAIL single_idle_time got %0d required %0d (accept %0d + 16)", t, idle, a); end
    exp_count++;
    n_cmp++; if (sample_count !== exp_count) begin n_bad++;
      $display("FAIL single_count got %0d required %0d", sample_count, exp_count); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++;
      $display("FAIL single_missing_access got %0d left required 0", exp_q.size()); end
    n_cmp++; if ({mem[3], mem[4], mem[6]} !== {32'h0000_ABCD, 32'd0, 32'd0}) begin n_bad++;
      $display("FAIL single_ram got %h %h %h required 0000abcd 0 0", mem[3], mem[4], mem[6]); end
  endtask

  task automatic test_poll_gap;
    int a, idle, t; bit ok, ok2;
    fin_q.delete(); fin_q.push_back(32'd0); fin_q.push_back(32'd0); fin_q.push_back(32'd5);
    post_sample(32'h1234_5678, 3, 1'b1, a, idle, ok);
    wait_idle(t, ok2);
    exp_count++;
    n_cmp++; if (!(ok && ok2) || t !== idle) begin n_bad++;
      $display("FAIL gap_idle_time got %0d required %0d", t, idle); end
    n_cmp++; if (sample_count !== exp_count || timeout_flag !== 1'b0) begin n_bad++;
      $display("FAIL gap_status got count=%0d to=%b required %0d 0", sample_count, timeout_flag, exp_count); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++;
      $display("FAIL gap_missing_access got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_timeout;
    int a, idle, t; bit ok, ok2;
    fin_q.delete(); mem[4] = 32'hDEAD_0004;
    post_sample(32'h0BAD_F00D, TOP, 1'b0, a, idle, ok);
    wait_idle(t, ok2);
    n_cmp++; if (!(ok && ok2) || t !== idle) begin n_bad++;
      $display("FAIL to_idle_time got %0d required %0d", t, idle); end
    n_cmp++; if (timeout_flag !== 1'b1 || sample_count !== exp_count) begin n_bad++;
      $display("FAIL to_status got to=%b count=%0d required 1 %0d", timeout_flag, sample_count, exp_count); end
    n_cmp++; if (mem[4] !== 32'hDEAD_0004 || mem[6] !== 32'd0) begin n_bad++;
      $display("FAIL to_ram got fin=%h rdy=%h required dead0004 0", mem[4], mem[6]); end
    n_cmp++; if (sample_ready !== 1'b1 || exp_q.size() != 0) begin n_bad++;
      $display("FAIL to_ready got ready=%b left=%0d required 1 0", sample_ready, exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals[3];
    int k, a, prev, idle, t; bit ok;
    vals[0] = 32'hA1A1_0001; vals[1] = 32'hB2B2_0002; vals[2] = 32'hC3C3_0003;
    fin_q.delete(); for (int i = 0; i < 3; i++) fin_q.push_back(32'hFFFF_FFFF);
    k = 0; prev = 0; idle = 0; sample_valid = 1'b1;
    for (int i = 0; i < 200 && k < 3; i++) begin
      if (sample_ready === 1'b1) begin
        sample_in = vals[k]; a = cyc + 1;
        push_expected(vals[k], 1, 1'b1, a, idle);
        if (k > 0) begin
          n_cmp++; if (a !== prev + 17) begin n_bad++;
            $display("FAIL b2b_accept_time got %0d required %0d", a, prev + 17); end
        end
        prev = a; k++;
      end else begin
        sample_in = $urandom;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    wait_idle(t, ok);
    exp_count += 16'd3;
    n_cmp++; if (k != 3 || !ok || t !== idle) begin n_bad++;
      $display("FAIL b2b_done got accepted=%0d idle=%0d required 3 %0d", k, t, idle); end
    n_cmp++; if (sample_count !== exp_count || exp_q.size() != 0) begin n_bad++;
      $display("FAIL b2b_count got %0d left=%0d required %0d 0", sample_count, exp_q.size(), exp_count); end
  endtask

  task automatic test_reset_mid;
    int a, idle; bit ok, hit;
    fin_q.delete(); fin_q.push_back(32'd1);
    post_sample(32'hCAFE_F00D, 1, 1'b1, a, idle, ok);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (loc_ramclk === 1'b1 && loc_ramwrite === 1'b1 && loc_ramaddress === 5'd6) hit = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!ok || !hit || cyc !== a + 4) begin n_bad++;
      $display("FAIL mid_edge_found got hit=%b t=%0d required 1 %0d", hit, cyc, a + 4); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({loc_ramclk, loc_ramwrite, loc_ramread, busy, sample_ready} !== 5'b00000) begin n_bad++;
      $display("FAIL mid_abort got clk/wr/rd/busy/ready=%b required 00000",
               {loc_ramclk, loc_ramwrite, loc_ramread, busy, sample_ready}); end
    n_cmp++; if (sample_count !== 16'd0 || timeout_flag !== 1'b0) begin n_bad++;
      $display("FAIL mid_cleared got count=%0d to=%b required 0 0", sample_count, timeout_flag); end
    n_cmp++; if (exp_q.size() != 3) begin n_bad++;
      $display("FAIL mid_access_count got %0d pending required 3", exp_q.size()); end
    exp_q.delete(); fin_q.delete(); exp_count = 16'd0;
    reset = 1'b1;
    #1;
    n_cmp++; if (sample_ready !== 1'b1) begin n_bad++;
      $display("FAIL mid_ready got %b required 1", sample_ready); end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    @(negedge clk);
    test_reset;
    test_single;
    test_poll_gap;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
